// File: rtl/fir_host_driver.sv
// Host-side driver for a pin-level FIR block: loads coefficients, streams samples
// with credit-based flow control and buffers FIR results in a small FIFO.
module fir_host_driver #(
    parameter int NUM_TAPS    = 4,
    parameter int FIR_LATENCY = 2,
    parameter int RES_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        stream_en,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  fir_x,
    output logic        fir_tvalid,
    output logic        fir_set_coeffs,
    input  logic [10:0] fir_y,
    output logic [10:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        coef_loaded,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    // Upstream handshake: a beat moves on a cycle where in_valid && in_ready.
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [TW-1:0]          tap_cnt;
    logic [FIR_LATENCY-1:0] vsr;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [10:0]            mem [RES_DEPTH];
    logic [CW:0]            occupancy;
    logic                   credit;
    logic                   accept;
    logic                   load_beat;
    logic                   stream_beat;
    logic                   last_tap;
    logic                   push;
    logic                   pop;

    // Results already in the FIFO plus those still inside the FIR consume credit.
    assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit      = occupancy < (CW + 1)'(RES_DEPTH);

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LOAD:   in_ready = 1'b1;
            S_STREAM: in_ready = stream_en && credit;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign load_beat   = accept && (state == S_LOAD);
    assign stream_beat = accept && (state == S_STREAM);
    assign last_tap    = tap_cnt == TW'(NUM_TAPS - 1);
    assign push        = vsr[FIR_LATENCY-1];
    assign pop         = res_valid && res_ready;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load_start)     state_next = S_LOAD;
                else if (stream_en) state_next = S_STREAM;
            end
            S_LOAD:   if (load_beat && last_tap) state_next = S_IDLE;
            S_STREAM: if (!stream_en) state_next = S_DRAIN;
            S_DRAIN:  if (inflight == '0) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tap_cnt     <= '0;
            coef_loaded <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && load_start) coef_loaded <= 1'b0;
            if (load_beat) begin
                if (last_tap) begin
                    tap_cnt     <= '0;
                    coef_loaded <= 1'b1;
                end else begin
                    tap_cnt <= tap_cnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_x          <= '0;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
        end else begin
            fir_tvalid     <= accept;
            fir_set_coeffs <= load_beat;
            if (accept) fir_x <= in_data;
        end
    end

    // One bit per sample beat travelling through the FIR; the top bit marks fir_y as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr      <= '0;
            inflight <= '0;
        end else begin
            vsr <= (vsr << 1) | FIR_LATENCY'(fir_tvalid && !fir_set_coeffs);
            case ({stream_beat, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fir_y;
    end

    assign res_data  = mem[rd_ptr];
    assign res_valid = fifo_count != '0;
    assign busy      = state != S_IDLE;
    assign fsm_state = state;

endmodule

// File: tb/tb_fir_host_driver.sv
// Directed bench for fir_host_driver: a FIR pin model returning 2*x, and
// scoreboard monitors for the pin beats and the result stream.
module tb_fir_host_driver;

    localparam int NUM_TAPS    = 4;
    localparam int FIR_LATENCY = 2;
    localparam int RES_DEPTH   = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        stream_en;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  fir_x;
    logic        fir_tvalid;
    logic        fir_set_coeffs;
    logic [10:0] fir_y;
    logic [10:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        coef_loaded;
    logic        busy;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    bit lat_on = 1'b0;

    logic [10:0] exp_q[$];
    logic [8:0]  pin_q[$];
    int          acc_q[$];
    logic [10:0] ypipe [FIR_LATENCY];

    fir_host_driver #(
        .NUM_TAPS(NUM_TAPS), .FIR_LATENCY(FIR_LATENCY), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .stream_en(stream_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fir_x(fir_x), .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs),
        .fir_y(fir_y), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .coef_loaded(coef_loaded), .busy(busy), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIR pin model: y = 2*x, valid FIR_LATENCY cycles after the strobe cycle
    always @(posedge clk) begin
        for (int i = FIR_LATENCY - 1; i > 0; i--) ypipe[i] <= ypipe[i-1];
        ypipe[0] <= fir_tvalid ? {2'b00, fir_x, 1'b0} : 11'h7ff;
    end
    assign fir_y = ypipe[FIR_LATENCY-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // pin monitor
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (fir_tvalid) begin
                if (pin_q.size() == 0) begin
                    chk("pin_spurious_tvalid", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    e = pin_q.pop_front();
                    chk("pin_beat", 32'({fir_set_coeffs, fir_x}), 32'(e));
                end
            end else begin
                chk("pin_idle_set_coeffs", 32'(fir_set_coeffs), 32'd0);
            end
        end
    end

    // result monitor
    always begin
        @(negedge clk);
        #2;
        if (rst_n && res_valid && res_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 32'(res_data), 32'h7ff);
            end else begin
                logic [10:0] e;
                int a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("res_data", 32'(res_data), 32'(e));
                if (lat_on) chk("res_latency", 32'(cyc - a), 32'(FIR_LATENCY + 1));
            end
        end
    end

    // driver tasks: called at a negedge, return at a negedge
    task automatic send(input logic [7:0] d, input bit is_load, input int max_wait, output bit ok);
        int w = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < max_wait) begin
            @(negedge clk);
            #1;
            w++;
        end
        ok = in_ready;
        if (ok) begin
            pin_q.push_back({is_load, d});
            if (!is_load) begin
                exp_q.push_back({2'b00, d, 1'b0});
                acc_q.push_back(cyc + 1);
            end
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] d, input bit is_load);
        bit ok;
        send(d, is_load, 50, ok);
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_empty();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("result_drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (fsm_state != S_IDLE && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("idle_timeout", 32'(fsm_state), 32'(S_IDLE));
    endtask

    task automatic check_reset_outputs();
        #1;
        chk("rst_fir_x", 32'(fir_x), 32'd0);
        chk("rst_fir_tvalid", 32'(fir_tvalid), 32'd0);
        chk("rst_fir_set_coeffs", 32'(fir_set_coeffs), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_coef_loaded", 32'(coef_loaded), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
    endtask

    task automatic load_coeffs(input logic [7:0] base);
        for (int i = 0; i < NUM_TAPS; i++) send_ok(base + 8'(i), 1'b1);
        in_valid = 1'b0;
        #1;
        chk("load_done_state", 32'(fsm_state), 32'(S_IDLE));
        chk("load_done_coef_loaded", 32'(coef_loaded), 32'd1);
    endtask

    // scoreboard scenarios
    initial begin
        bit ok;
        int accepted;
        int p0;
        rst_n = 1'b0; load_start = 1'b0; stream_en = 1'b0;
        in_data = '0; in_valid = 1'b0; res_ready = 1'b1;
        #12;
        check_reset_outputs();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // coefficient load 1,2,3,4
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        chk("load_state", 32'(fsm_state), 32'(S_LOAD));
        chk("load_coef_loaded_low", 32'(coef_loaded), 32'd0);
        @(negedge clk);
        load_coeffs(8'h01);

        // streaming with latency check
        stream_en = 1'b1;
        lat_on = 1'b1;
        @(negedge clk);
        send_ok(8'h10, 1'b0);
        send_ok(8'h20, 1'b0);
        send_ok(8'h30, 1'b0);
        in_valid = 1'b0;
        wait_empty();
        lat_on = 1'b0;

        // backpressure: only RES_DEPTH credits while results are not popped
        res_ready = 1'b0;
        accepted = 0;
        for (int i = 1; i <= 6; i++) begin
            send(8'(i * 8'h11), 1'b0, 3, ok);
            if (ok) accepted++;
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepted", 32'(accepted), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        send_ok(8'h55, 1'b0);
        send_ok(8'h66, 1'b0);
        in_valid = 1'b0;
        wait_empty();

        // drain: stream_en falls the cycle after an accepted sample
        p0 = pop_cnt;
        send_ok(8'h7f, 1'b0);
        in_valid = 1'b0;
        stream_en = 1'b0;
        @(negedge clk);
        #1;
        chk("drain_state", 32'(fsm_state), 32'(S_DRAIN));
        chk("drain_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("drain_result_delivered", 32'(pop_cnt - p0), 32'd1);
        chk("drain_busy_low", 32'(busy), 32'd0);

        // reset after 2 of 4 coefficient beats
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        chk("reload_coef_loaded_cleared", 32'(coef_loaded), 32'd0);
        @(negedge clk);
        send_ok(8'ha1, 1'b1);
        send_ok(8'ha2, 1'b1);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        pin_q.delete();
        exp_q.delete();
        acc_q.delete();
        check_reset_outputs();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        load_coeffs(8'h05);

        // priority: load_start beats stream_en in IDLE
        @(negedge clk);
        load_start = 1'b1;
        stream_en = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        stream_en = 1'b0;
        #1;
        chk("prio_load_wins", 32'(fsm_state), 32'(S_LOAD));
        @(negedge clk);
        load_coeffs(8'h09);

        // load_start ignored while streaming
        stream_en = 1'b1;
        @(negedge clk); @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        chk("stream_ignores_load", 32'(fsm_state), 32'(S_STREAM));
        chk("stream_keeps_coef_loaded", 32'(coef_loaded), 32'd1);
        @(negedge clk);
        send_ok(8'h33, 1'b0);
        in_valid = 1'b0;
        stream_en = 1'b0;
        wait_idle();
        wait_empty();
        repeat (3) @(negedge clk);
        chk("final_pin_q_empty", 32'(pin_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_host_driver.md
FIR_HOST_DRIVER -- requirements
Module: fir_host_driver

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4: number of coefficient beats per load.
REQ-002 SHALL have parameter FIR_LATENCY, default 2: cycles from a fir_tvalid cycle to a valid fir_y, range 1..8.
REQ-003 SHALL have parameter RES_DEPTH, default 4: result FIFO depth, power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 load_start  input  1  single-cycle request to begin a coefficient load.
REQ-007 stream_en  input  1  level; high enables sample streaming.
REQ-008 in_data  input  8  upstream beat: coefficient in LOAD, sample in STREAM.
REQ-009 in_valid  input  1  upstream beat valid.
REQ-010 in_ready  output  1  upstream beat accepted when in_valid && in_ready.
REQ-011 fir_x  output  8  pin-side data to the FIR input bus.
REQ-012 fir_tvalid  output  1  pin-side strobe for one beat.
REQ-013 fir_set_coeffs  output  1  pin-side coefficient-load qualifier.
REQ-014 fir_y  input  11  pin-side FIR result, unsigned.
REQ-015 res_data  output  11  head of result FIFO.
REQ-016 res_valid  output  1  result FIFO not empty.
REQ-017 res_ready  input  1  downstream pop when res_valid && res_ready.
REQ-018 coef_loaded  output  1  high once a complete load has finished.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, STREAM and DRAIN.
REQ-021 IDLE -> LOAD on load_start; else IDLE -> STREAM on stream_en; load_start wins when both are high.
REQ-022 LOAD: in_ready=1; each accepted beat increments the tap counter; after beat NUM_TAPS is accepted: -> IDLE, coef_loaded=1, counter=0.
REQ-023 coef_loaded SHALL clear on entry to LOAD and stay 0 until that load completes.
REQ-024 STREAM: in_ready = stream_en && (fifo_count + inflight < RES_DEPTH); inflight = sample beats issued but not yet captured.
REQ-025 STREAM -> DRAIN when stream_en falls; DRAIN: in_ready=0; DRAIN -> IDLE when inflight=0.
REQ-026 load_start SHALL be ignored in STREAM and DRAIN.
REQ-027 Pin outputs SHALL be registered: a beat accepted in cycle t drives fir_x=in_data and fir_tvalid=1 during cycle t+1 only; fir_set_coeffs=1 in that cycle if the beat was a LOAD beat, else 0.
REQ-028 With no accepted beat, fir_tvalid=0 and fir_set_coeffs=0, and fir_x holds its last value.
REQ-029 A STREAM beat driven on the pins in cycle u SHALL have fir_y sampled at the end of cycle u+FIR_LATENCY and pushed to the FIFO; a FIR_LATENCY-deep valid shift register tracks this, with one bit per in-flight beat.
REQ-030 LOAD beats SHALL NOT produce FIFO pushes.
REQ-031 The FIFO SHALL be first-in first-out, with no overflow (guaranteed by REQ-024) and no underflow (pop only when res_valid).
REQ-032 A simultaneous push and pop SHALL leave the count unchanged.
REQ-033 Read and write pointers SHALL wrap modulo RES_DEPTH.
REQ-034 res_data SHALL present the FIFO head combinationally from storage.
REQ-035 Back-to-back beats SHALL be supported: one beat per cycle while credit allows.

Reset
REQ-036 rst_n low SHALL immediately set state=IDLE and clear these outputs: fir_x=0, fir_tvalid=0, fir_set_coeffs=0, in_ready=0, res_valid=0, coef_loaded=0, busy=0.
REQ-037 rst_n low SHALL also clear the tap counter, valid shift register, inflight count, FIFO pointers and FIFO count.
REQ-038 Reset mid-LOAD or mid-STREAM SHALL discard partial loads and in-flight results; no fir_tvalid pulse follows the reset release without a new accepted beat.

Verification
REQ-039 Load: load_start, then coefficients 0x01,0x02,0x03,0x04 back-to-back -> four consecutive fir_tvalid=fir_set_coeffs=1 cycles with fir_x=1,2,3,4; then coef_loaded=1 and state IDLE.
REQ-040 Stream: stream_en=1, samples 0x10,0x20,0x30 with res_ready=1 and a model FIR returning fir_y=2*x -> res_data 0x020,0x040,0x060 in order, each arriving FIR_LATENCY+1 cycles after acceptance.
REQ-041 Backpressure: res_ready=0 and 6 samples offered -> exactly 4 accepted and in_ready=0; release res_ready -> the remaining 2 are accepted, and all 6 results are delivered in order.
REQ-042 Drain: stream_en dropped the cycle after a sample is accepted -> state DRAIN, that result is still delivered, then IDLE, with busy low only after inflight=0.
REQ-043 Reset: rst_n asserted after 2 of 4 coefficient beats -> outputs as in REQ-036 immediately; a new full load then completes normally.
REQ-044 Priority: load_start and stream_en high together in IDLE -> LOAD entered; load_start pulsed during STREAM -> no effect and fir_set_coeffs stays 0.
